// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8 x 16-bit register file with an independent write
// port, plus a four-state sequencer that reads Rn into A and Rm into B on
// consecutive edges. It then presents shifted/selected operands with a
// one-cycle valid pulse.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [$clog2(NREGS)-1:0] rm,
  input  logic [1:0]               shift,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [DATA_W-1:0]        sximm5,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_num,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     op_valid,
  output logic [DATA_W-1:0]        val_A,
  output logic [DATA_W-1:0]        val_B
);
  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, DONE} state_t;

  // Fetch request captured when start is accepted
  typedef struct packed {
    logic [IW-1:0]     rn;
    logic [IW-1:0]     rm;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] imm;
  } req_t;

  state_t                       state, state_nxt;
  req_t                         req_q;
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]            a_q, b_q, b_sh;
  logic                         ld_req, ld_a, ld_b;

  // Register file write port; runs regardless of sequencer state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      regs         <= '0;
    else if (wr_en) regs[wr_num] <= wr_data;
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ_A;
      READ_A:  state_nxt = READ_B;
      READ_B:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs and latch load strobes
  always_comb begin
    busy     = (state != IDLE);
    op_valid = (state == DONE);
    ld_req   = (state == IDLE) && start;
    ld_a     = (state == READ_A);
    ld_b     = (state == READ_B);
  end

  // Request capture and operand latches; reads see the pre-edge register
  // value, so a same-edge write to the same index is not bypassed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      if (ld_req) req_q <= '{rn: rn, rm: rm, shift: shift, asel: asel,
                             bsel: bsel, imm: sximm5};
      if (ld_a)   a_q   <= regs[req_q.rn];
      if (ld_b)   b_q   <= regs[req_q.rm];
    end
  end

  // Shifter on the registered B operand
  always_comb begin
    b_sh = b_q;
    case (req_q.shift)
      2'b01:   b_sh = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_sh = b_q;
    endcase
  end

  assign val_A = req_q.asel ? '0 : a_q;
  assign val_B = req_q.bsel ? req_q.imm : b_sh;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a register-file model produces
// expected operands that are queued at start and compared on op_valid.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset, start, asel, bsel, wr_en;
  logic [2:0]  rn, rm, wr_num;
  logic [1:0]  shift;
  logic [15:0] sximm5, wr_data;
  logic        busy, op_valid;
  logic [15:0] val_A, val_B;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [15:0] mdl[8];
  int          pulses = 0;
  logic        prev_v = 1'b0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm),
    .shift(shift), .asel(asel), .bsel(bsel), .sximm5(sximm5),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .busy(busy), .op_valid(op_valid), .val_A(val_A), .val_B(val_B)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'b00:   return b;
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      default: return {b[15], b[15:1]};
    endcase
  endfunction

  // Scoreboard: compare operands whenever the DUT reports valid
  always @(negedge clk) begin
    if (op_valid === 1'b1) begin
      pulses++;
      checks++;
      if (prev_v) begin
        errors++;
        $display("FAIL op_valid_consecutive: op_valid high two cycles running");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got A=%h B=%h with nothing queued", val_A, val_B);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if ({val_A, val_B} !== e) begin
          errors++;
          $display("FAIL operands: got A=%h B=%h expected A=%h B=%h",
                   val_A, val_B, e[31:16], e[15:0]);
        end
      end
    end
    prev_v = (op_valid === 1'b1);
  end

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_num = idx; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[idx] = d;
  endtask

  // Issue one fetch and report how many cycles until op_valid was seen
  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [15:0] im,
                       output int lat);
    @(negedge clk);
    rn = a; rm = b; shift = sh; asel = as; bsel = bs; sximm5 = im; start = 1'b1;
    sb.push_back({as ? 16'h0 : mdl[a], bs ? im : shf(mdl[b], sh)});
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (op_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; asel = 0; bsel = 0; wr_en = 0;
    rn = 0; rm = 0; wr_num = 0; shift = 0; sximm5 = 0; wr_data = 0;
    foreach (mdl[i]) mdl[i] = 16'h0;
    #1;
    checks++;
    if ({busy, op_valid, val_A, val_B} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b op_valid=%b A=%h B=%h required all 0",
               busy, op_valid, val_A, val_B);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    wr(3'd2, 16'h0007);
    wr(3'd5, 16'h0003);
    fetch(3'd2, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 3", lat);
    end
    checks++;
    if (val_A !== 16'h0007 || val_B !== 16'h0003) begin
      errors++;
      $display("FAIL basic_hold: A=%h B=%h required 0007/0003", val_A, val_B);
    end
  endtask

  task automatic test_shift();
    int lat;
    wr(3'd1, 16'h8001);
    for (int s = 0; s < 4; s++) begin
      fetch(3'd2, 3'd1, 2'(s), 1'b0, 1'b0, 16'h0, lat);
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL shift_latency: shift=%0d got %0d required 3", s, lat);
      end
    end
  endtask

  task automatic test_selects();
    int lat;
    wr(3'd0, 16'h1234);
    fetch(3'd0, 3'd1, 2'b00, 1'b1, 1'b1, 16'hFFF0, lat);
    checks++;
    if (val_A !== 16'h0000 || val_B !== 16'hFFF0) begin
      errors++;
      $display("FAIL selects: A=%h B=%h required 0000/FFF0", val_A, val_B);
    end
  endtask

  // Write to R4 one edge before B is read (seen) and on the read edge (old value)
  task automatic test_write_during();
    wr(3'd3, 16'h0001);
    for (int late = 0; late < 2; late++) begin
      wr(3'd4, 16'h0002);
      @(negedge clk);
      rn = 3'd3; rm = 3'd4; shift = 0; asel = 0; bsel = 0; start = 1'b1;
      sb.push_back({16'h0001, late ? 16'h0002 : 16'h00AA});
      @(negedge clk);                       // READ_A
      start = 1'b0;
      if (late == 0) begin wr_en = 1'b1; wr_num = 3'd4; wr_data = 16'h00AA; end
      @(negedge clk);                       // READ_B
      if (late == 1) begin wr_en = 1'b1; wr_num = 3'd4; wr_data = 16'h00AA; end
      else wr_en = 1'b0;
      @(negedge clk);                       // DONE
      wr_en = 1'b0;
      mdl[4] = 16'h00AA;
      checks++;
      if (op_valid !== 1'b1 || val_B !== (late ? 16'h0002 : 16'h00AA)) begin
        errors++;
        $display("FAIL write_during late=%0d: op_valid=%b B=%h", late, op_valid, val_B);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int p0;
    logic eb, ev;
    p0 = pulses;
    @(negedge clk);
    rn = 3'd2; rm = 3'd1; shift = 2'b11; asel = 0; bsel = 0; start = 1'b1;
    sb.push_back({mdl[2], shf(mdl[1], 2'b11)});
    sb.push_back({mdl[2], shf(mdl[1], 2'b11)});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      eb = (i % 4) != 0;
      ev = (i % 4) == 3;
      checks++;
      if (busy !== eb || op_valid !== ev) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: busy=%b op_valid=%b required %b/%b",
                 i, busy, op_valid, eb, ev);
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (pulses - p0 != 2) begin
      errors++;
      $display("FAIL busy_pulses: got %0d required 2", pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    @(negedge clk);
    rn = 3'd4; rm = 3'd2; shift = 0; asel = 0; bsel = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                         // now in READ_B
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, op_valid, val_A, val_B} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b op_valid=%b A=%h B=%h required all 0",
               busy, op_valid, val_A, val_B);
    end
    foreach (mdl[i]) mdl[i] = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    p0 = pulses;
    repeat (6) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL reset_mid_valid: %0d op_valid pulses after abort", pulses - p0);
    end
  endtask

  task automatic test_after_reset();
    int lat;
    fetch(3'd2, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0, lat);
    checks++;
    if (val_A !== 16'h0 || val_B !== 16'h0) begin
      errors++;
      $display("FAIL regs_cleared: A=%h B=%h required 0000/0000", val_A, val_B);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_selects();
    test_write_during();
    test_busy_ignore();
    test_reset_mid();
    test_after_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
